// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps one imem read in flight, and feeds decode through a skid-buffered valid/ready.
// Build option FETCH_MISALIGN_CHK_EN: misaligned redirect targets are reported to decode instead of fetched.
module fetch_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] if_pc,
    output logic [6:0]       if_opcode,
    output logic [2:0]       if_funct3,
    output logic [6:0]       if_funct7,
    output logic             if_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic             req_q, req_d;
    logic             discard_q, discard_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_instr_q, out_instr_d;
    logic [WIDTH-1:0] out_pc_q, out_pc_d;
    logic             out_mis_q, out_mis_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [WIDTH-1:0] tgt;
    logic             tgt_mis;
    logic             consumed;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        discard_d    = discard_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_mis_d    = out_mis_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        consumed     = out_valid_q && if_ready;
`ifdef FETCH_MISALIGN_CHK_EN
        tgt     = redirect_target;
        tgt_mis = |redirect_target[1:0];
`else
        tgt     = redirect_target & {{(WIDTH-2){1'b1}}, 2'b00};
        tgt_mis = 1'b0;
`endif

        if (imem_rvalid && discard_q)
            discard_d = 1'b0;
        if (consumed) begin
            out_valid_d = 1'b0;
            out_instr_d = NOP_INSTR;
            out_mis_d   = 1'b0;
        end

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_q && imem_gnt) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + WIDTH'(4);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid && !discard_q) begin
                    if (!out_valid_q || consumed) begin
                        out_valid_d = 1'b1;
                        out_instr_d = imem_rdata;
                        out_pc_d    = fetch_pc_q;
                        out_mis_d   = 1'b0;
                        state_d     = REQ;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = fetch_pc_q;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                // HOLD with an empty skid is the misaligned-target stall; only a redirect leaves it
                if (consumed && skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_instr_d  = skid_instr_q;
                    out_pc_d     = skid_pc_q;
                    out_mis_d    = 1'b0;
                    skid_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) begin
            // a read granted now or still in flight must have its response dropped
            discard_d    = ((state_q == WAIT) && !imem_rvalid) || (req_q && imem_gnt) ||
                           (discard_q && !imem_rvalid);
            pc_d         = tgt;
            skid_valid_d = 1'b0;
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
            out_mis_d    = 1'b0;
            state_d      = REQ;
            if (tgt_mis) begin
                out_valid_d = 1'b1;
                out_pc_d    = redirect_target;
                out_mis_d   = 1'b1;
                state_d     = HOLD;
            end
        end

        req_d = (state_d == REQ) && !discard_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            req_q        <= 1'b0;
            discard_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= RESET_PC;
            out_mis_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            req_q        <= req_d;
            discard_q    <= discard_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_mis_q    <= out_mis_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = pc_q;
    assign if_valid      = out_valid_q;
    assign if_instr      = out_instr_q;
    assign if_pc         = out_pc_q;
    assign if_opcode     = out_instr_q[6:0];
    assign if_funct3     = out_instr_q[14:12];
    assign if_funct7     = out_instr_q[31:25];
    assign if_misaligned = out_mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory/redirect model predicts the delivered instruction stream,
// a negedge monitor pops and compares on every decode handshake.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] STALE  = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid, if_ready, if_misaligned;
    logic [31:0] if_instr, if_pc;
    logic [6:0]  if_opcode, if_funct7;
    logic [2:0]  if_funct3;

    always #5 clk = ~clk;

    fetch_unit #(.WIDTH(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_opcode(if_opcode), .if_funct3(if_funct3), .if_funct7(if_funct7),
        .if_misaligned(if_misaligned)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } item_t;

    item_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;

    int unsigned p_gnt = 100, p_ready = 100, p_red = 0, max_lat = 0;
    int          force_mode = 0;
    logic [31:0] force_tgt = '0;
    bit          ready_always = 1'b0;

    bit          busy = 1'b0, stale = 1'b0, stalled = 1'b0;
    logic [31:0] b_addr = '0;
    int unsigned lat = 0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] salt = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h0) return 32'h00A00093;
        w = (a * 32'h9E3779B1) ^ salt;
        if (w == STALE) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_instr", if_instr, NOP);
        check("rst_if_pc", if_pc, RST_PC);
        check("rst_if_misaligned", 32'(if_misaligned), 32'h0);
    endtask

    // One cycle of memory/redirect/decode stimulus plus the reference model of what must be delivered.
    task automatic step();
        bit          do_rv, do_gnt, do_red;
        logic [31:0] tgt;
        item_t       it;
        @(posedge clk); #1;
        do_rv = 1'b0;
        if (busy) begin
            if (lat == 0) do_rv = 1'b1;
            else lat--;
        end
        do_gnt = ($urandom_range(99) < p_gnt);
        do_red = ($urandom_range(999) < p_red);
        tgt    = $urandom & 32'h0000_0FFF;
        case (force_mode)
            1: do_red = busy && !do_rv;
            2: begin do_gnt = 1'b1; do_red = imem_req; end
            3: do_red = do_rv;
            4: do_red = 1'b1;
            default: ;
        endcase
        if (force_mode != 0 && do_red) begin
            tgt        = force_tgt;
            force_mode = 0;
        end

        if (busy)              check("req_while_outstanding", 32'(imem_req), 32'h0);
        if (exp_q.size() >= 2) check("req_with_skid_full", 32'(imem_req), 32'h0);
        if (stalled)           check("req_while_misaligned", 32'(imem_req), 32'h0);

        redirect_valid  = do_red;
        redirect_target = tgt;
        imem_rvalid     = do_rv;
        imem_rdata      = $urandom;
        if (do_rv) begin
            imem_rdata = (stale || do_red) ? STALE : mem_word(b_addr);
            if (!stale && !do_red) begin
                it.pc    = b_addr;
                it.instr = mem_word(b_addr);
                it.mis   = 1'b0;
                exp_q.push_back(it);
            end
            busy = 1'b0;
        end

        imem_gnt = do_gnt;
        if (imem_req && do_gnt) begin
            check("grant_addr", imem_addr, exp_pc);
            busy   = 1'b1;
            stale  = 1'b0;
            b_addr = exp_pc;
            lat    = $urandom_range(max_lat);
            exp_pc = exp_pc + 32'd4;
        end
        if (do_red) begin
            if (busy) stale = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
            stalled = (tgt[1:0] != 2'b00);
            if (!stalled) exp_pc = tgt;
`else
            exp_pc = {tgt[31:2], 2'b00};
`endif
        end
        if_ready = ($urandom_range(99) < p_ready);
    endtask

    bit          prev_hold = 1'b0, prev_hs = 1'b0;
    logic [31:0] prev_instr = '0, prev_pc = '0;

    always @(negedge clk) begin : monitor
        bit    hs;
        item_t e;
        if (!rst_n) begin
            prev_hold = 1'b0;
            prev_hs   = 1'b0;
        end else begin
            hs = if_valid && if_ready;
            if (prev_hold) begin
                check("hold_valid", 32'(if_valid), 32'h1);
                check("hold_instr", if_instr, prev_instr);
                check("hold_pc", if_pc, prev_pc);
            end
            if (!if_valid) begin
                check("idle_instr", if_instr, NOP);
                check("idle_misaligned", 32'(if_misaligned), 32'h0);
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_instr: got pc=%h instr=%h, expected nothing", if_pc, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e.pc);
                    check("if_instr", if_instr, e.instr);
                    check("if_opcode", 32'(if_opcode), 32'(e.instr[6:0]));
                    check("if_funct3", 32'(if_funct3), 32'(e.instr[14:12]));
                    check("if_funct7", 32'(if_funct7), 32'(e.instr[31:25]));
                    check("if_misaligned", 32'(if_misaligned), 32'(e.mis));
                end
                if (ready_always) begin
                    checks++;
                    if (prev_hs) begin
                        failures++;
                        $display("FAIL back_to_back: got consecutive handshakes, expected at most one per 2 cycles");
                    end
                end
            end
            prev_hold  = if_valid && !if_ready && !redirect_valid;
            prev_instr = if_instr;
            prev_pc    = if_pc;
            prev_hs    = hs;
            if (redirect_valid) begin
                exp_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
                if (redirect_target[1:0] != 2'b00) begin
                    e.pc    = redirect_target;
                    e.instr = NOP;
                    e.mis   = 1'b1;
                    exp_q.push_back(e);
                end
`endif
            end
        end
    end

    initial begin
        int n;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_target = '0; if_ready = 1'b0;
        salt = $urandom;
        #12;
        check_reset_outputs();
        @(negedge clk); #2 rst_n = 1'b1;

        // zero-wait memory, decode always ready
        ready_always = 1'b1;
        repeat (20) step();
        ready_always = 1'b0;

        // decode stalls long enough for output and skid to fill
        p_ready = 0;
        repeat (8) step();
        p_ready = 100;
        repeat (10) step();

        // redirect while a read is in flight, with gnt, and with rvalid
        max_lat = 2;
        force_tgt = 32'h100; force_mode = 1;
        repeat (14) step();
        force_tgt = 32'h200; force_mode = 2;
        repeat (12) step();
        force_tgt = 32'h300; force_mode = 3;
        repeat (12) step();

`ifdef FETCH_MISALIGN_CHK_EN
        p_ready = 0;
        force_tgt = 32'h102; force_mode = 4;
        repeat (4) step();
        p_ready = 100;
        repeat (4) step();
        force_tgt = 32'h0; force_mode = 4;
        repeat (10) step();
`endif

        // randomized traffic
        p_gnt = 70; p_ready = 60; p_red = 60; max_lat = 3;
        repeat (1500) step();

        // async reset while a read is outstanding
        p_red = 0; p_gnt = 100; p_ready = 100;
        force_tgt = 32'h40; force_mode = 4;
        n = 0;
        do begin step(); n++; end while (!(busy && !stale) && n < 60);
        checks++;
        if (!(busy && !stale)) begin
            failures++;
            $display("FAIL wait_outstanding: got no outstanding read within %0d cycles, expected one", n);
        end
        #3 rst_n = 1'b0;
        #1 check_reset_outputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
        busy = 1'b0; stale = 1'b0; stalled = 1'b0;
        exp_q.delete();
        exp_pc = RST_PC;
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (20) step();

        // drain everything the model still expects
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin step(); n++; end
        check("drain_empty", 32'(exp_q.size()), 32'h0);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
